// File: rtl/guess_game_core.sv
// guess_game_core
//   Two-player number-guessing engine. Player A keys in a secret sequence of
//   symbols, then player B gets up to MAX_TURNS guesses. Every submitted guess
//   is scored for per-position hits and a length comparison. The block sits
//   between the debounced push-button front end and the display logic.
//
// Ports
//   clk           system clock, all state on the rising edge
//   reset         asynchronous, active-high; clears all state
//   key           debounced level key inputs, bit i = symbol i
//   enter         debounced level enter key
//   secret_map    bit [k*MAX_LEN+p] set when secret position p holds symbol k
//   guess_map     same layout for the guess being entered
//   secret_len    symbols stored in the secret
//   guess_len     symbols stored in the current guess
//   phase         0=SECRET, 1=GUESS (also during scoring), 2=WIN, 3=LOSE
//   result_valid  one-cycle pulse when a guess has been scored
//   hits          matching positions below min(secret_len, guess_len)
//   equal/bigger/smaller  length comparison of the last scored guess
//   turns_used    guesses scored without a win
//   win / lose    terminal-state flags
module guess_game_core #(
  parameter int  NUM_KEYS  = 4,
  parameter int  MAX_LEN   = 7,
  parameter int  MIN_LEN   = 4,
  parameter int  MAX_TURNS = 3,
  localparam int LW        = $clog2(MAX_LEN + 1),
  localparam int TW        = $clog2(MAX_TURNS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         key,
  input  logic                        enter,
  output logic [NUM_KEYS*MAX_LEN-1:0] secret_map,
  output logic [NUM_KEYS*MAX_LEN-1:0] guess_map,
  output logic [LW-1:0]               secret_len,
  output logic [LW-1:0]               guess_len,
  output logic [1:0]                  phase,
  output logic                        result_valid,
  output logic [LW-1:0]               hits,
  output logic                        equal,
  output logic                        bigger,
  output logic                        smaller,
  output logic [TW-1:0]               turns_used,
  output logic                        win,
  output logic                        lose
);

  localparam int MW = NUM_KEYS * MAX_LEN;

  // Low two bits of the architectural states are the phase code; SCORE is
  // internal and reports as GUESS.
  localparam logic [2:0] ST_SECRET = 3'd0;
  localparam logic [2:0] ST_GUESS  = 3'd1;
  localparam logic [2:0] ST_WIN    = 3'd2;
  localparam logic [2:0] ST_LOSE   = 3'd3;
  localparam logic [2:0] ST_SCORE  = 3'd4;

  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_MIN   = LW'(MIN_LEN);
  localparam logic [TW-1:0] TURNS_MAX = TW'(MAX_TURNS);

  logic [2:0]          state_q, state_d;
  logic [NUM_KEYS-1:0] key_q;
  logic                enter_q;
  logic [MW-1:0]       secret_map_q, secret_map_d;
  logic [MW-1:0]       guess_map_q, guess_map_d;
  logic [LW-1:0]       secret_len_q, secret_len_d;
  logic [LW-1:0]       guess_len_q, guess_len_d;
  logic [LW-1:0]       hits_q, hits_d;
  logic                equal_q, equal_d;
  logic                bigger_q, bigger_d;
  logic                smaller_q, smaller_d;
  logic [TW-1:0]       turns_used_q, turns_used_d;
  logic                result_valid_q, result_valid_d;

  logic [NUM_KEYS-1:0] key_edge;
  logic                enter_edge;
  logic                key_single;
  logic [LW-1:0]       hits_c;
  logic                win_c;

  // Sets the bit for every symbol in sym at position pos; callers pass a
  // one-hot sym, so exactly one bit is added.
  function automatic logic [MW-1:0] store_symbol(input logic [MW-1:0]       map,
                                                 input logic [NUM_KEYS-1:0] sym,
                                                 input logic [LW-1:0]       pos);
    logic [MW-1:0] res;
    res = map;
    for (int k = 0; k < NUM_KEYS; k++) begin
      for (int p = 0; p < MAX_LEN; p++) begin
        if (sym[k] && (pos == LW'(p))) res[k*MAX_LEN+p] = 1'b1;
      end
    end
    return res;
  endfunction

  // Positions beyond either length are all-zero in that map, so a plain
  // per-position AND already restricts the count to p < min(lengths).
  function automatic logic [LW-1:0] count_hits(input logic [MW-1:0] s_map,
                                               input logic [MW-1:0] g_map);
    logic [LW-1:0] cnt;
    logic          match;
    cnt = '0;
    for (int p = 0; p < MAX_LEN; p++) begin
      match = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        match = match | (s_map[k*MAX_LEN+p] & g_map[k*MAX_LEN+p]);
      end
      if (match) cnt = cnt + LW'(1);
    end
    return cnt;
  endfunction

  assign key_edge   = key & ~key_q;
  assign enter_edge = enter & ~enter_q;
  // Chords (several simultaneous key edges) carry no usable symbol.
  assign key_single = $onehot(key_edge);

  assign hits_c = count_hits(secret_map_q, guess_map_q);
  assign win_c  = (guess_len_q == secret_len_q) && (hits_c == secret_len_q);

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    secret_map_d   = secret_map_q;
    guess_map_d    = guess_map_q;
    secret_len_d   = secret_len_q;
    guess_len_d    = guess_len_q;
    hits_d         = hits_q;
    equal_d        = equal_q;
    bigger_d       = bigger_q;
    smaller_d      = smaller_q;
    turns_used_d   = turns_used_q;
    result_valid_d = 1'b0;

    case (state_q)
      ST_SECRET: begin
        if (secret_len_q == LEN_MAX) begin
          state_d = ST_GUESS;
        end else if (enter_edge) begin
          // Enter wins over a coincident key edge; the key edge is dropped.
          if (secret_len_q >= LEN_MIN) state_d = ST_GUESS;
        end else if (key_single) begin
          secret_map_d = store_symbol(secret_map_q, key_edge, secret_len_q);
          secret_len_d = secret_len_q + LW'(1);
        end
      end

      ST_GUESS: begin
        if (enter_edge) begin
          if (guess_len_q >= LEN_MIN) state_d = ST_SCORE;
        end else if (key_single && (guess_len_q != LEN_MAX)) begin
          guess_map_d = store_symbol(guess_map_q, key_edge, guess_len_q);
          guess_len_d = guess_len_q + LW'(1);
        end
      end

      ST_SCORE: begin
        hits_d         = hits_c;
        equal_d        = (guess_len_q == secret_len_q);
        bigger_d       = (secret_len_q > guess_len_q);
        smaller_d      = (secret_len_q < guess_len_q);
        result_valid_d = 1'b1;
        if (win_c) begin
          state_d = ST_WIN;
        end else begin
          turns_used_d = turns_used_q + TW'(1);
          if (turns_used_d == TURNS_MAX) begin
            state_d = ST_LOSE;
          end else begin
            state_d     = ST_GUESS;
            guess_map_d = '0;
            guess_len_d = '0;
          end
        end
      end

      default: ; // WIN and LOSE are terminal; only reset leaves them
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the symbol maps are plain flops, not a RAM, and are cleared on reset
  // so a new game never shows a stale secret.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SECRET;
      key_q          <= '0;
      enter_q        <= 1'b0;
      secret_map_q   <= '0;
      guess_map_q    <= '0;
      secret_len_q   <= '0;
      guess_len_q    <= '0;
      hits_q         <= '0;
      equal_q        <= 1'b0;
      bigger_q       <= 1'b0;
      smaller_q      <= 1'b0;
      turns_used_q   <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_q          <= key;
      enter_q        <= enter;
      secret_map_q   <= secret_map_d;
      guess_map_q    <= guess_map_d;
      secret_len_q   <= secret_len_d;
      guess_len_q    <= guess_len_d;
      hits_q         <= hits_d;
      equal_q        <= equal_d;
      bigger_q       <= bigger_d;
      smaller_q      <= smaller_d;
      turns_used_q   <= turns_used_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign secret_map   = secret_map_q;
  assign guess_map    = guess_map_q;
  assign secret_len   = secret_len_q;
  assign guess_len    = guess_len_q;
  assign phase        = (state_q == ST_SCORE) ? 2'd1 : state_q[1:0];
  assign result_valid = result_valid_q;
  assign hits         = hits_q;
  assign equal        = equal_q;
  assign bigger       = bigger_q;
  assign smaller      = smaller_q;
  assign turns_used   = turns_used_q;
  assign win          = (state_q == ST_WIN);
  assign lose         = (state_q == ST_LOSE);

endmodule

// File: tb/tb_guess_game_core.sv
// Testbench for guess_game_core: scenario tasks plus randomized games checked
// against a queue-based model of the game rules. A second instance with
// NUM_KEYS=6, MAX_LEN=9, MAX_TURNS=5 reruns one scenario.
module tb_guess_game_core;

  localparam int NK   = 4;
  localparam int ML   = 7;
  localparam int MINL = 4;
  localparam int MT   = 3;
  localparam int LW   = $clog2(ML + 1);
  localparam int TW   = $clog2(MT + 1);
  localparam int MW   = NK * ML;
  localparam int VW   = 2*MW + 3*LW + 2 + 3 + TW + 2;

  localparam int NK2  = 6;
  localparam int ML2  = 9;
  localparam int MT2  = 5;
  localparam int LW2  = $clog2(ML2 + 1);
  localparam int TW2  = $clog2(MT2 + 1);

  localparam int PH_SECRET = 0;
  localparam int PH_GUESS  = 1;
  localparam int PH_WIN    = 2;
  localparam int PH_LOSE   = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NK-1:0]  key;
  logic           enter;
  logic [MW-1:0]  secret_map, guess_map;
  logic [LW-1:0]  secret_len, guess_len, hits;
  logic [1:0]     phase;
  logic           result_valid, equal, bigger, smaller, win, lose;
  logic [TW-1:0]  turns_used;

  logic               reset2;
  logic [NK2-1:0]     key2;
  logic               enter2;
  logic [NK2*ML2-1:0] secret_map2, guess_map2;
  logic [LW2-1:0]     secret_len2, guess_len2, hits2;
  logic [1:0]         phase2;
  logic               result_valid2, equal2, bigger2, smaller2, win2, lose2;
  logic [TW2-1:0]     turns_used2;

  guess_game_core #(.NUM_KEYS(NK), .MAX_LEN(ML), .MIN_LEN(MINL), .MAX_TURNS(MT)) dut (
    .clk(clk), .reset(reset), .key(key), .enter(enter),
    .secret_map(secret_map), .guess_map(guess_map),
    .secret_len(secret_len), .guess_len(guess_len), .phase(phase),
    .result_valid(result_valid), .hits(hits), .equal(equal),
    .bigger(bigger), .smaller(smaller), .turns_used(turns_used),
    .win(win), .lose(lose)
  );

  guess_game_core #(.NUM_KEYS(NK2), .MAX_LEN(ML2), .MIN_LEN(MINL), .MAX_TURNS(MT2)) dut2 (
    .clk(clk), .reset(reset2), .key(key2), .enter(enter2),
    .secret_map(secret_map2), .guess_map(guess_map2),
    .secret_len(secret_len2), .guess_len(guess_len2), .phase(phase2),
    .result_valid(result_valid2), .hits(hits2), .equal(equal2),
    .bigger(bigger2), .smaller(smaller2), .turns_used(turns_used2),
    .win(win2), .lose(lose2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the game as sequences of symbols and a phase number.
  int sec_q[$];
  int gue_q[$];
  int m_phase, m_turns, m_hits;
  bit m_eq, m_big, m_small;

  function automatic void model_reset();
    sec_q.delete();
    gue_q.delete();
    m_phase = PH_SECRET;
    m_turns = 0;
    m_hits  = 0;
    m_eq    = 1'b0;
    m_big   = 1'b0;
    m_small = 1'b0;
  endfunction

  function automatic void model_key(input int k);
    if (m_phase == PH_SECRET) begin
      if (sec_q.size() < ML) sec_q.push_back(k);
      if (sec_q.size() == ML) m_phase = PH_GUESS;
    end else if (m_phase == PH_GUESS && gue_q.size() < ML) begin
      gue_q.push_back(k);
    end
  endfunction

  // Returns 1 when the enter press leads to a scored guess.
  function automatic bit model_enter();
    int n;
    if (m_phase == PH_SECRET) begin
      if (sec_q.size() >= MINL) m_phase = PH_GUESS;
      return 1'b0;
    end
    if (m_phase != PH_GUESS || gue_q.size() < MINL) return 1'b0;
    n = (sec_q.size() < gue_q.size()) ? sec_q.size() : gue_q.size();
    m_hits = 0;
    for (int p = 0; p < n; p++) if (sec_q[p] == gue_q[p]) m_hits++;
    m_eq    = (sec_q.size() == gue_q.size());
    m_big   = (sec_q.size() > gue_q.size());
    m_small = (sec_q.size() < gue_q.size());
    if (m_eq && m_hits == sec_q.size()) begin
      m_phase = PH_WIN;
    end else begin
      m_turns++;
      if (m_turns == MT) m_phase = PH_LOSE;
      else gue_q.delete();
    end
    return 1'b1;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {secret_map, guess_map, secret_len, guess_len, phase, hits,
            equal, bigger, smaller, turns_used, win, lose};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [MW-1:0] sm, gm;
    sm = '0;
    gm = '0;
    foreach (sec_q[p]) sm[sec_q[p]*ML+p] = 1'b1;
    foreach (gue_q[p]) gm[gue_q[p]*ML+p] = 1'b1;
    return {sm, gm, LW'(sec_q.size()), LW'(gue_q.size()), 2'(m_phase), LW'(m_hits),
            m_eq, m_big, m_small, TW'(m_turns), m_phase == PH_WIN, m_phase == PH_LOSE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key   = '0;
    enter = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic press_key(input int k);
    key = NK'(1) << k;
    tick();
    key = '0;
    tick();
    model_key(k);
  endtask

  task automatic press_multi();
    int a, b;
    a = $urandom_range(0, NK-1);
    b = (a + 1 + $urandom_range(0, NK-2)) % NK;
    key = (NK'(1) << a) | (NK'(1) << b);
    tick();
    key = '0;
    tick();
  endtask

  // Enter press, optionally with key edges in the same cycle. Records phase
  // during the cycle after the edge and result_valid over three cycles.
  task automatic do_enter(input logic [NK-1:0] with_keys, input string name);
    logic [4:0] obs, exp;
    bit scored;
    enter = 1'b1;
    key   = with_keys;
    tick();
    enter  = 1'b0;
    key    = '0;
    obs[4:3] = phase;
    obs[2]   = result_valid;
    tick();
    obs[1] = result_valid;
    tick();
    obs[0] = result_valid;
    scored = model_enter();
    exp = scored ? {2'd1, 3'b010} : {2'(m_phase), 3'b000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s timing: got phase/valid %b expected %b", name, obs, exp);
    end
  endtask

  task automatic test_reset();
    model_reset();
    tick();
    checks++;
    if ({obs_vec(), result_valid} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected all zero", {obs_vec(), result_valid});
    end
    // A key held through reset release produces one edge.
    key = NK'(2);
    reset = 1'b0;
    tick();
    key = '0;
    tick();
    model_key(1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL held_key_at_release: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_win();
    logic [VW-1:0] snap;
    do_reset();
    for (int i = 0; i < 4; i++) press_key(i);
    do_enter('0, "win_secret_enter");
    for (int i = 0; i < 4; i++) press_key(i);
    do_enter('0, "win_guess_enter");
    checks++;
    if ({hits, equal, win, phase, turns_used} !== {3'd4, 1'b1, 1'b1, 2'd2, 2'd0}) begin
      errors++;
      $display("FAIL win_result: got hits=%0d eq=%b win=%b phase=%0d turns=%0d expected 4 1 1 2 0",
               hits, equal, win, phase, turns_used);
    end
    snap = obs_vec();
    press_key(2);
    do_enter(NK'(1), "win_enter_ignored");
    checks++;
    if (obs_vec() !== snap || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL win_terminal: got %h expected %h", obs_vec(), snap);
    end
  endtask

  task automatic test_miss_and_lose();
    logic [VW-1:0] snap;
    do_reset();
    press_key(0); press_key(1); press_key(2); press_key(3); press_key(0);
    do_enter('0, "miss_secret_enter");
    press_key(0); press_key(1); press_key(2); press_key(1);
    do_enter('0, "miss_guess_enter");
    checks++;
    if ({hits, bigger, equal, smaller, turns_used, guess_len, phase} !==
        {3'd3, 1'b1, 1'b0, 1'b0, 2'd1, 3'd0, 2'd1}) begin
      errors++;
      $display("FAIL miss_result: got hits=%0d big=%b eq=%b sm=%b turns=%0d glen=%0d phase=%0d expected 3 1 0 0 1 0 1",
               hits, bigger, equal, smaller, turns_used, guess_len, phase);
    end
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) press_key(2 + g);
      do_enter('0, "lose_guess_enter");
    end
    checks++;
    if ({turns_used, lose, phase} !== {2'd3, 1'b1, 2'd3} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL lose_result: got turns=%0d lose=%b phase=%0d expected 3 1 3", turns_used, lose, phase);
    end
    snap = obs_vec();
    press_key(1);
    press_multi();
    do_enter('0, "lose_enter_ignored");
    checks++;
    if (obs_vec() !== snap) begin
      errors++;
      $display("FAIL lose_terminal: got %h expected %h", obs_vec(), snap);
    end
  endtask

  task automatic test_auto_advance();
    do_reset();
    for (int i = 0; i < ML; i++) press_key($urandom_range(0, NK-1));
    checks++;
    if (phase !== 2'd1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL auto_advance: got phase=%0d state %h expected phase=1 state %h", phase, obs_vec(), exp_vec());
    end
    press_key(3);
    checks++;
    if (guess_len !== 3'd1 || secret_len !== 3'd7) begin
      errors++;
      $display("FAIL eighth_key: got glen=%0d slen=%0d expected 1 7", guess_len, secret_len);
    end
    press_key(0); press_key(1);
    do_enter('0, "short_guess_enter");
    checks++;
    if (guess_len !== 3'd3 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL short_guess_ignored: got glen=%0d expected 3", guess_len);
    end
    for (int i = 0; i < 5; i++) press_key($urandom_range(0, NK-1));
    repeat (3) tick();
    checks++;
    if ({guess_len, phase, turns_used, result_valid} !== {3'd7, 2'd1, 2'd0, 1'b0} ||
        obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL guess_full: got glen=%0d phase=%0d turns=%0d valid=%b expected 7 1 0 0",
               guess_len, phase, turns_used, result_valid);
    end
  endtask

  task automatic test_edge_rules();
    do_reset();
    key = NK'(5);
    tick();
    key = '0;
    tick();
    checks++;
    if (secret_len !== 3'd0 || secret_map !== '0) begin
      errors++;
      $display("FAIL chord_ignored: got slen=%0d map=%h expected 0 0", secret_len, secret_map);
    end
    key = NK'(4);
    repeat (10) tick();
    key = '0;
    tick();
    model_key(2);
    checks++;
    if (secret_len !== 3'd1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL held_key_once: got slen=%0d expected 1", secret_len);
    end
    press_key(1); press_key(3);
    do_enter('0, "early_secret_enter");
    press_key(0);
    do_enter(NK'(2), "key_with_enter");
    checks++;
    if ({phase, secret_len} !== {2'd1, 3'd4} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL key_with_enter: got phase=%0d slen=%0d expected 1 4", phase, secret_len);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) press_key(i);
    do_enter('0, "mid_secret_enter");
    press_key(1); press_key(2);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({obs_vec(), result_valid} !== '0) begin
      errors++;
      $display("FAIL async_reset_guess: got %h expected all zero", {obs_vec(), result_valid});
    end
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) press_key(i);
    do_enter('0, "score_secret_enter");
    for (int i = 0; i < 4; i++) press_key(3 - i);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({obs_vec(), result_valid} !== '0) begin
      errors++;
      $display("FAIL async_reset_score: got %h expected all zero", {obs_vec(), result_valid});
    end
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    checks++;
    if (result_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_no_result: got valid=%b state %h expected 0 %h", result_valid, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int slen, glen, steps, sym;
    bit copy;
    for (int r = 0; r < 12; r++) begin
      do_reset();
      slen = $urandom_range(MINL, ML);
      for (int i = 0; i < slen; i++) begin
        if ($urandom_range(0, 7) == 0) press_multi();
        press_key($urandom_range(0, NK-1));
      end
      do_enter('0, "rnd_secret_enter");
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rnd_secret r%0d: got %h expected %h", r, obs_vec(), exp_vec());
      end
      steps = 0;
      while (m_phase == PH_GUESS && steps < 10) begin
        glen = $urandom_range(MINL-1, ML);
        copy = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < glen; i++) begin
          sym = (copy && i < sec_q.size()) ? sec_q[i] : int'($urandom_range(0, NK-1));
          press_key(sym);
        end
        do_enter('0, "rnd_guess_enter");
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL rnd_guess r%0d s%0d: got %h expected %h", r, steps, obs_vec(), exp_vec());
        end
        steps++;
      end
    end
  endtask

  task automatic test_param_variant();
    int s[ML2];
    logic [NK2*ML2-1:0] smap;
    reset2 = 1'b0;
    smap = '0;
    for (int i = 0; i < ML2; i++) begin
      s[i] = $urandom_range(0, NK2-1);
      smap[s[i]*ML2+i] = 1'b1;
      key2 = NK2'(1) << s[i];
      tick();
      key2 = '0;
      tick();
    end
    checks++;
    if ({phase2, secret_len2, secret_map2} !== {2'd1, 4'd9, smap}) begin
      errors++;
      $display("FAIL p2_secret: got phase=%0d slen=%0d map=%h expected 1 9 %h", phase2, secret_len2, secret_map2, smap);
    end
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < ML2 - 1 + g; i++) begin
        key2 = NK2'(1) << s[i];
        tick();
        key2 = '0;
        tick();
      end
      enter2 = 1'b1;
      tick();
      enter2 = 1'b0;
      tick();
      checks++;
      if (g == 0 && {result_valid2, hits2, bigger2, equal2, turns_used2, guess_len2, phase2} !==
                    {1'b1, 4'd8, 1'b1, 1'b0, 3'd1, 4'd0, 2'd1}) begin
        errors++;
        $display("FAIL p2_miss: got valid=%b hits=%0d big=%b eq=%b turns=%0d glen=%0d phase=%0d expected 1 8 1 0 1 0 1",
                 result_valid2, hits2, bigger2, equal2, turns_used2, guess_len2, phase2);
      end else if (g == 1 && {result_valid2, hits2, equal2, win2, turns_used2, phase2} !==
                             {1'b1, 4'd9, 1'b1, 1'b1, 3'd1, 2'd2}) begin
        errors++;
        $display("FAIL p2_win: got valid=%b hits=%0d eq=%b win=%b turns=%0d phase=%0d expected 1 9 1 1 1 2",
                 result_valid2, hits2, equal2, win2, turns_used2, phase2);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    key    = '0;
    enter  = 1'b0;
    reset2 = 1'b1;
    key2   = '0;
    enter2 = 1'b0;
    test_reset();
    test_win();
    test_miss_and_lose();
    test_auto_advance();
    test_edge_rules();
    test_reset_mid();
    test_random();
    test_param_variant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/guess_game_core.md
Name: guess_game_core

Overview:
Parametrised, synchronous successor of the two-player number-guessing engine. Player A enters a secret sequence of key symbols. Player B then gets up to MAX_TURNS guesses. Each guess is scored for exact match, per-position hits and a length comparison. The block sits between the debounced push-button front end and the 7-segment/LED display logic, and exposes per-key position bitmaps for the display.

Parameters:
NUM_KEYS, 4, number of symbol keys (>=2)
MAX_LEN, 7, maximum symbols per sequence (>=MIN_LEN)
MIN_LEN, 4, minimum symbols before enter is accepted (>=1)
MAX_TURNS, 3, guesses allowed before lose (>=1)
(Derived: LW = clog2(MAX_LEN+1), TW = clog2(MAX_TURNS+1).)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
key  input  NUM_KEYS  debounced level key inputs, bit i = symbol i
enter  input  1  debounced level enter key
secret_map  output  NUM_KEYS*MAX_LEN  bit [k*MAX_LEN+p] = 1 if secret position p holds symbol k
guess_map  output  NUM_KEYS*MAX_LEN  same layout for the current guess
secret_len  output  LW  symbols stored in the secret
guess_len  output  LW  symbols stored in the current guess
phase  output  2  0=SECRET, 1=GUESS, 2=WIN, 3=LOSE
result_valid  output  1  one-cycle pulse when a guess has been scored
hits  output  LW  positions p < min(secret_len, guess_len) where the symbols match
equal  output  1  last scored guess_len == secret_len
bigger  output  1  last scored secret_len > guess_len
smaller  output  1  last scored secret_len < guess_len
turns_used  output  TW  guesses scored without a win
win  output  1  high in WIN
lose  output  1  high in LOSE

Behaviour:
- Reset (async assert, sync release): every output 0, phase=SECRET, both buffers and edge-detect registers cleared. The edge-detect registers reset to 0, so a key already held at release produces one edge.
- Edge detect: key_q and enter_q are registered copies of the inputs. A press is key & ~key_q (or enter & ~enter_q) and is acted on in the same cycle it is seen. Holding a key produces exactly one symbol.
- Multiple key edges in one cycle: all ignored.
- Enter edge in the same cycle as a key edge: enter is processed; the key edge is dropped.
- SECRET phase:
  - A key edge k with secret_len < MAX_LEN stores symbol k at position secret_len and increments secret_len.
  - When secret_len reaches MAX_LEN, the block moves to GUESS on the next clock.
  - An enter edge with secret_len >= MIN_LEN moves to GUESS. An enter edge with secret_len < MIN_LEN is ignored.
- GUESS phase:
  - A key edge stores the symbol into the guess buffer the same way as in SECRET.
  - Key edges with guess_len == MAX_LEN are ignored; there is no auto-submit.
  - An enter edge with guess_len >= MIN_LEN enters an internal one-cycle SCORE state. An enter edge with guess_len < MIN_LEN is ignored.
- SCORE (one cycle; phase still reads 1):
  - On the exit edge, register hits, equal, bigger and smaller; exactly one of equal/bigger/smaller is high from then on.
  - result_valid is high for the cycle after SCORE, so latency from the enter edge to result_valid is 2 cycles.
  - Win iff guess_len == secret_len and hits == secret_len. On a win, go to WIN.
  - Otherwise increment turns_used. If the new value equals MAX_TURNS, go to LOSE. Otherwise return to GUESS with guess_map and guess_len cleared.
  - Score outputs hold until the next scoring or reset.
- WIN and LOSE: terminal. All key and enter inputs are ignored, and secret_map stays visible. Only reset leaves these states.
- Mid-operation reset, in any state including SCORE: immediate clear. No result_valid is produced for an interrupted score.
- Width rule: all length and count arithmetic is unsigned at LW/TW bits. Saturation at MAX_LEN and MAX_TURNS prevents wrap.

Test Plan:
- Secret 0,1,2,3 + enter, then guess 0,1,2,3 + enter -> result_valid 2 cycles after the enter edge; hits=4, equal=1, win=1, phase=2, turns_used=0.
- Secret 0,1,2,3,0 + enter; guess 0,1,2,1 + enter -> hits=3, bigger=1, turns_used=1, guess_len=0, phase=1.
- Three wrong guesses (MAX_TURNS=3) -> turns_used=3, lose=1, phase=3; further key and enter edges change nothing.
- Secret entry of 7 symbols with no enter -> phase=1 automatically; an 8th key edge lands in the guess buffer (guess_len=1). Enter at guess_len=3 is ignored.
- Simultaneous key[0]+key[2] edges -> nothing stored. Key held for 10 cycles -> one symbol. Key edge together with enter (secret_len=4) -> phase=1, secret_len stays 4.
- Reset asserted mid-guess and during the SCORE cycle -> all outputs 0 asynchronously, no result_valid. Rerun one scenario at NUM_KEYS=6, MAX_LEN=9, MAX_TURNS=5.
